mdu_param: RTL and testbench
============================

MDU_PARAM -- requirements
Module: mdu_param

Interface
REQ-001 SHALL provide parameter WIDTH, default 32: operand and HI/LO register width.
REQ-002 SHALL provide parameter MUL_LAT, default 5: busy cycles for multiply-class ops; legal range 1..255.
REQ-003 SHALL provide parameter DIV_LAT, default 10: busy cycles for divide-class ops; legal range 1..255.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous active-high reset.
REQ-006 SHALL have port start  input  1  issue strobe; op/a/b sampled on the same edge.
REQ-007 SHALL have port op  input  3  operation: 0 mult, 1 multu, 2 div, 3 divu, 4 madd, 5 maddu, 6 mthi, 7 mtlo.
REQ-008 SHALL have port a  input  WIDTH  first operand (rs value).
REQ-009 SHALL have port b  input  WIDTH  second operand (rt value).
REQ-010 SHALL have port busy  output  1  registered; high while an operation is in flight.
REQ-011 SHALL have port hi  output  WIDTH  architectural HI register.
REQ-012 SHALL have port lo  output  WIDTH  architectural LO register.

Function
REQ-013 SHALL implement a two-state FSM, IDLE and RUN, with a down-counter wide enough for max(MUL_LAT, DIV_LAT).
REQ-014 In IDLE, start=1 with op 0..5 SHALL latch a, b and op, load the counter with MUL_LAT (ops 0,1,4,5) or DIV_LAT (ops 2,3), and enter RUN; busy=1 from the next cycle.
REQ-015 With start asserted in cycle 0, busy SHALL be 1 in cycles 1..LAT and 0 in cycle LAT+1; new hi/lo SHALL become visible in cycle LAT+1, on the same edge that clears busy.
REQ-016 hi and lo SHALL hold their previous values throughout RUN; no intermediate value is visible.
REQ-017 mult: {hi,lo} SHALL equal the 2*WIDTH-bit signed product of a and b.
REQ-018 multu: {hi,lo} SHALL equal the 2*WIDTH-bit unsigned product.
REQ-019 madd / maddu: {hi,lo} SHALL equal the old {hi,lo} plus the signed / unsigned product, modulo 2^(2*WIDTH); old {hi,lo} is the value at the start edge.
REQ-020 div: lo SHALL equal the signed quotient truncated toward zero; hi SHALL equal the remainder carrying the sign of a.
REQ-021 divu: lo SHALL equal the unsigned quotient; hi SHALL equal the unsigned remainder.
REQ-022 Divide by zero (ops 2,3, b=0): lo SHALL be all ones and hi SHALL equal a; no exception signalled.
REQ-023 Signed overflow (div, a = most-negative, b = all ones): lo SHALL equal a and hi SHALL be 0.
REQ-024 mthi / mtlo with start=1 in IDLE SHALL write a into hi / lo at that edge; busy stays 0; the other register is unchanged.
REQ-025 start=1 while busy=1 SHALL be ignored for all ops, including mthi/mtlo; the in-flight operation completes unaffected.
REQ-026 On the completion edge (busy 1 -> 0), a concurrent start SHALL be ignored; a new op is accepted only when busy=0 at the start edge.
REQ-027 Operands a, b and op changing during RUN SHALL have no effect on the result.
REQ-028 Implementation may compute iteratively or in one step, provided observable timing matches REQ-015 exactly.

Reset
REQ-029 reset=1 at an edge SHALL force IDLE, busy=0, hi=0, lo=0, counter=0, regardless of state.
REQ-030 reset asserted mid-RUN SHALL abort the operation; its result is never written.
REQ-031 reset SHALL take priority over start on the same edge.

Verification
REQ-032 WIDTH=32, MUL_LAT=5: mult a=0xFFFFFFFD b=5 at cycle 0 -> busy=1 cycles 1..5, cycle 6 hi=0xFFFFFFFF lo=0xFFFFFFF1 busy=0.
REQ-033 DIV_LAT=10: div a=0xFFFFFFF9 (-7) b=2 -> cycle 11 lo=0xFFFFFFFD hi=0xFFFFFFFF; divu a=7 b=2 -> lo=3 hi=1.
REQ-034 divu a=0x12345678 b=0 -> lo=0xFFFFFFFF hi=0x12345678; div a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000 hi=0.
REQ-035 mthi a=1, mtlo a=0xFFFFFFFF, then maddu a=b=1 -> hi=2 lo=0 after MUL_LAT cycles (carry into hi).
REQ-036 multu started, mtlo and second multu issued while busy, reset pulsed cycle 3 -> both ignored, busy=0 hi=lo=0 next cycle, no later write.
REQ-037 Repeat REQ-032 with WIDTH=16, MUL_LAT=1: mult 0xFFFD*5 -> busy one cycle only, hi=0xFFFF lo=0xFFF1.

Source files
------------

// File: rtl/mdu_param.sv
// Multiply/divide unit with HI/LO registers and fixed, parameterised latency.
// Results are computed in one step from latched operands and committed on the
// edge that ends the busy window.
module mdu_param #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned MUL_LAT = 5,
   parameter int unsigned DIV_LAT = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
   localparam int unsigned CW      = $clog2(MAX_LAT + 1);
   localparam int unsigned W2      = 2 * WIDTH;

   localparam logic [2:0] OP_MULT  = 3'd0;
   localparam logic [2:0] OP_MULTU = 3'd1;
   localparam logic [2:0] OP_DIV   = 3'd2;
   localparam logic [2:0] OP_DIVU  = 3'd3;
   localparam logic [2:0] OP_MADD  = 3'd4;
   localparam logic [2:0] OP_MADDU = 3'd5;
   localparam logic [2:0] OP_MTHI  = 3'd6;
   localparam logic [2:0] OP_MTLO  = 3'd7;

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state;
   logic [CW-1:0]    cnt;
   logic [2:0]       op_q;
   logic [WIDTH-1:0] a_q, b_q;

   logic [W2-1:0]    prod_s, prod_u, res;
   logic [WIDTH-1:0] mag_a, mag_b, q_m, r_m, q_s, r_s, qu, ru;
   logic             neg_a, neg_b;

   // Result datapath from latched operands; old {hi,lo} is stable during RUN.
   always_comb begin
      prod_s = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
      prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
      neg_a  = a_q[WIDTH-1];
      neg_b  = b_q[WIDTH-1];
      mag_a  = neg_a ? (WIDTH'(0) - a_q) : a_q;
      mag_b  = neg_b ? (WIDTH'(0) - b_q) : b_q;
      q_m    = (mag_b == '0) ? '0 : mag_a / mag_b;
      r_m    = (mag_b == '0) ? '0 : mag_a % mag_b;
      q_s    = (neg_a ^ neg_b) ? (WIDTH'(0) - q_m) : q_m;
      r_s    = neg_a ? (WIDTH'(0) - r_m) : r_m;
      qu     = (b_q == '0) ? '0 : a_q / b_q;
      ru     = (b_q == '0) ? '0 : a_q % b_q;
      res    = {hi, lo};
      case (op_q)
         OP_MULT:  res = prod_s;
         OP_MULTU: res = prod_u;
         OP_MADD:  res = {hi, lo} + prod_s;
         OP_MADDU: res = {hi, lo} + prod_u;
         OP_DIV:   res = (b_q == '0) ? {a_q, {WIDTH{1'b1}}} : {r_s, q_s};
         OP_DIVU:  res = (b_q == '0) ? {a_q, {WIDTH{1'b1}}} : {ru, qu};
         default:  res = {hi, lo};
      endcase
   end

   // Control FSM, latency counter and architectural HI/LO registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         busy  <= 1'b0;
         cnt   <= '0;
         hi    <= '0;
         lo    <= '0;
         op_q  <= '0;
         a_q   <= '0;
         b_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  case (op)
                     OP_MTHI: hi <= a;
                     OP_MTLO: lo <= a;
                     default: begin
                        op_q  <= op;
                        a_q   <= a;
                        b_q   <= b;
                        cnt   <= (op == OP_DIV || op == OP_DIVU) ? CW'(DIV_LAT) : CW'(MUL_LAT);
                        busy  <= 1'b1;
                        state <= RUN;
                     end
                  endcase
               end
            end
            RUN: begin
               if (cnt <= CW'(1)) begin
                  {hi, lo} <= res;
                  busy     <= 1'b0;
                  cnt      <= '0;
                  state    <= IDLE;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mdu_param.sv
// Scoreboard bench for mdu_param: a 32-bit default instance and a 16-bit,
// single-cycle-multiply instance. Expected results are queued at issue time
// and checked by a monitor when busy falls.
module tb_mdu_param;

   typedef struct {
      logic [63:0] hl;
      int          lat;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset_a = 1'b1, start_a = 1'b0;
   logic [2:0]  op_a = 3'd0;
   logic [31:0] a_a = '0, b_a = '0;
   logic        busy_a;
   logic [31:0] hi_a, lo_a;

   logic        reset_b = 1'b1, start_b = 1'b0;
   logic [2:0]  op_b = 3'd0;
   logic [15:0] a_b = '0, b_b = '0;
   logic        busy_b;
   logic [15:0] hi_b, lo_b;

   int checks = 0;
   int errors = 0;
   exp_t qa[$];
   exp_t qb[$];
   logic        pb   [2];
   int          cnt  [2];
   logic [63:0] hold [2];

   mdu_param #(.WIDTH(32), .MUL_LAT(5), .DIV_LAT(10)) dut_a (
      .clk(clk), .reset(reset_a), .start(start_a), .op(op_a),
      .a(a_a), .b(b_a), .busy(busy_a), .hi(hi_a), .lo(lo_a));

   mdu_param #(.WIDTH(16), .MUL_LAT(1), .DIV_LAT(10)) dut_b (
      .clk(clk), .reset(reset_b), .start(start_b), .op(op_b),
      .a(a_b), .b(b_b), .busy(busy_b), .hi(hi_b), .lo(lo_b));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %h want %h", nm, act, expv);
      end
   endtask

   // Per-instance completion monitor: hold check during busy, result/latency at fall.
   task automatic mon(input int id, input logic bz, input logic [63:0] hl);
      exp_t e;
      if (bz === 1'b1) begin
         if (!pb[id]) begin
            cnt[id]  = 1;
            hold[id] = hl;
         end else begin
            cnt[id]++;
            chk($sformatf("hold%0d", id), hl, hold[id]);
         end
      end else if (pb[id]) begin
         if (id == 0 && qa.size() > 0) e = qa.pop_front();
         else if (id == 1 && qb.size() > 0) e = qb.pop_front();
         else begin
            checks++;
            errors++;
            $display("FAIL unexpected_completion%0d: got completion want none", id);
            pb[id] = 1'b0;
            return;
         end
         chk($sformatf("result%0d", id), hl, e.hl);
         chk($sformatf("latency%0d", id), 64'(cnt[id]), 64'(e.lat));
      end
      pb[id] = (bz === 1'b1);
   endtask

   initial begin
      pb[0] = 1'b0; pb[1] = 1'b0;
      cnt[0] = 0;   cnt[1] = 0;
      hold[0] = '0; hold[1] = '0;
   end

   // Monitor samples on the falling edge, away from the active edge.
   always @(negedge clk) begin
      mon(0, busy_a, {hi_a, lo_a});
      mon(1, busy_b, {32'h0, hi_b, lo_b});
   end

   task automatic issue_a(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv);
      @(negedge clk);
      start_a = 1'b1; op_a = op; a_a = av; b_a = bv;
      @(posedge clk);
      #1 start_a = 1'b0;
   endtask

   task automatic issue_b(input logic [2:0] op, input logic [15:0] av, input logic [15:0] bv);
      @(negedge clk);
      start_b = 1'b1; op_b = op; a_b = av; b_b = bv;
      @(posedge clk);
      #1 start_b = 1'b0;
   endtask

   task automatic wait_idle(input int id);
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (id == 0 && busy_a === 1'b0) return;
         if (id == 1 && busy_b === 1'b0) return;
      end
      checks++;
      errors++;
      $display("FAIL timeout%0d: got busy stuck want idle", id);
   endtask

   task automatic run_a(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                        input logic [63:0] hl, input int lat);
      exp_t e;
      e.hl = hl; e.lat = lat;
      qa.push_back(e);
      issue_a(op, av, bv);
      wait_idle(0);
   endtask

   task automatic run_b(input logic [2:0] op, input logic [15:0] av, input logic [15:0] bv,
                        input logic [63:0] hl, input int lat);
      exp_t e;
      e.hl = hl; e.lat = lat;
      qb.push_back(e);
      issue_b(op, av, bv);
      wait_idle(1);
   endtask

   initial begin
      exp_t e;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_busy", 64'(busy_a), 64'h0);
      chk("reset_hilo", {hi_a, lo_a}, 64'h0);
      reset_a = 1'b0;
      reset_b = 1'b0;

      // Multiply and divide vectors on the 32-bit instance
      run_a(3'd0, 32'hFFFF_FFFD, 32'd5,        64'hFFFF_FFFF_FFFF_FFF1, 5);
      run_a(3'd1, 32'hFFFF_FFFD, 32'd5,        64'h0000_0004_FFFF_FFF1, 5);
      run_a(3'd2, 32'hFFFF_FFF9, 32'd2,        64'hFFFF_FFFF_FFFF_FFFD, 10);
      run_a(3'd3, 32'd7,         32'd2,        64'h0000_0001_0000_0003, 10);
      run_a(3'd3, 32'h1234_5678, 32'd0,        64'h1234_5678_FFFF_FFFF, 10);
      run_a(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 10);
      run_a(3'd2, 32'd7,         32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, 10);
      run_a(3'd2, 32'hFFFF_FFF9, 32'd0,        64'hFFFF_FFF9_FFFF_FFFF, 10);

      // mthi/mtlo write immediately, then maddu carries into hi
      issue_a(3'd6, 32'd1, 32'd0);
      @(negedge clk);
      chk("mthi_hilo", {hi_a, lo_a}, 64'h0000_0001_FFFF_FFFF);
      chk("mthi_busy", 64'(busy_a), 64'h0);
      issue_a(3'd7, 32'hFFFF_FFFF, 32'd0);
      @(negedge clk);
      chk("mtlo_hilo", {hi_a, lo_a}, 64'h0000_0001_FFFF_FFFF);
      run_a(3'd5, 32'd1, 32'd1,                64'h0000_0002_0000_0000, 5);
      run_a(3'd4, 32'hFFFF_FFFF, 32'd3,        64'h0000_0001_FFFF_FFFD, 5);

      // Start held through RUN and the completion edge with changing operands
      e.hl = 64'h0000_0000_0000_000C; e.lat = 5;
      qa.push_back(e);
      @(negedge clk);
      start_a = 1'b1; op_a = 3'd1; a_a = 32'd3; b_a = 32'd4;
      @(posedge clk);
      #1 op_a = 3'd7; a_a = 32'h55; b_a = 32'h99;
      repeat (5) @(posedge clk);
      #1 start_a = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("ignored_start_hilo", {hi_a, lo_a}, 64'h0000_0000_0000_000C);

      // Reset mid-RUN aborts; mtlo and multu issued while busy are ignored
      e.hl = 64'h0; e.lat = 3;
      qa.push_back(e);
      @(negedge clk);
      start_a = 1'b1; op_a = 3'd1; a_a = 32'd5; b_a = 32'd6;
      @(posedge clk);
      #1 op_a = 3'd7; a_a = 32'h77;
      @(posedge clk);
      #1 op_a = 3'd1; a_a = 32'd9; b_a = 32'd9;
      @(posedge clk);
      #1 start_a = 1'b0; reset_a = 1'b1;
      @(posedge clk);
      #1 reset_a = 1'b0;
      repeat (10) @(negedge clk);
      chk("abort_busy", 64'(busy_a), 64'h0);
      chk("abort_hilo", {hi_a, lo_a}, 64'h0);

      // Reset wins over a concurrent mthi
      @(negedge clk);
      reset_a = 1'b1; start_a = 1'b1; op_a = 3'd6; a_a = 32'h5;
      @(posedge clk);
      #1 reset_a = 1'b0; start_a = 1'b0;
      @(negedge clk);
      chk("reset_prio_hilo", {hi_a, lo_a}, 64'h0);

      // 16-bit instance with single-cycle multiply
      run_b(3'd0, 16'hFFFD, 16'd5,   64'h0000_0000_FFFF_FFF1, 1);
      run_b(3'd1, 16'hFFFF, 16'hFFFF, 64'h0000_0000_FFFE_0001, 1);
      run_b(3'd3, 16'd100,  16'd7,   64'h0000_0000_0002_000E, 10);

      repeat (3) @(negedge clk);
      chk("queue_a_empty", 64'(qa.size()), 64'h0);
      chk("queue_b_empty", 64'(qb.size()), 64'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
